// File: rtl/ref_dac_sched.sv
// Arbitrates host and loop DAC codes onto a single SPI serializer and tracks the committed code.
// Optional loop-step clamp when REF_DAC_SLEW_EN is defined.
module ref_dac_sched #(
    parameter int               DAC_W        = 16,
    parameter int               MIN_GAP      = 400,
    parameter logic [DAC_W-1:0] DEFAULT_CODE = 16'h7FFF,
    parameter int               MAX_STEP     = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             loop_valid,
    input  logic [DAC_W-1:0] loop_code,
    output logic             loop_ready,
    input  logic             host_valid,
    input  logic [DAC_W-1:0] host_code,
    output logic             host_ready,
    input  logic             host_hold,
    output logic             spi_start,
    output logic [DAC_W-1:0] spi_data,
    input  logic             spi_busy,
    output logic [DAC_W-1:0] dac_code,
    output logic [7:0]       drop_cnt,
    output logic             spi_err
);
`ifdef REF_DAC_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    localparam logic signed [DAC_W:0] STEP = (DAC_W+1)'(MAX_STEP);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_GAP} state_t;

    state_t           r_state, w_nstate;
    logic             r_act;
    logic             r_host_pend, r_loop_pend;
    logic [DAC_W-1:0] r_host_buf, r_loop_buf, r_spi_data, r_dac;
    logic [7:0]       r_drop;
    logic             r_err;
    logic [15:0]      r_gap;
    logic [3:0]       r_tmo;

    logic             w_launch, w_commit, w_tmo, w_sel_host;
    logic             w_loop_acc, w_drop;
    logic [DAC_W-1:0] w_word, w_loop_word;
    logic signed [DAC_W:0] w_diff, w_up, w_dn;

    // Clamp datapath; w_up/w_dn MSB flags overflow/underflow of dac_code +/- step.
    always_comb begin
        w_diff      = $signed({1'b0, r_loop_buf}) - $signed({1'b0, r_dac});
        w_up        = $signed({1'b0, r_dac}) + STEP;
        w_dn        = $signed({1'b0, r_dac}) - STEP;
        w_loop_word = r_loop_buf;
        if (SLEW_EN && (w_diff > STEP))
            w_loop_word = w_up[DAC_W] ? '1 : w_up[DAC_W-1:0];
        else if (SLEW_EN && (w_diff < -STEP))
            w_loop_word = w_dn[DAC_W] ? '0 : w_dn[DAC_W-1:0];
    end

    assign w_sel_host = r_host_pend;
    assign w_word     = w_sel_host ? r_host_buf : w_loop_word;

    always_comb begin
        w_nstate = r_state;
        w_launch = 1'b0;
        w_commit = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_act && (r_host_pend || r_loop_pend)) begin
                    w_launch = 1'b1;
                    w_nstate = S_START;
                end
            end
            S_START: begin
                if (spi_busy) begin
                    w_nstate = S_SHIFT;
                end else if (r_tmo == 4'd14) begin
                    w_tmo    = 1'b1;
                    w_nstate = S_GAP;
                end
            end
            S_SHIFT: begin
                if (!spi_busy) begin
                    w_commit = 1'b1;
                    w_nstate = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == 16'd0) w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // A loop entry consumed by a launch this cycle may be refilled without counting a drop.
    assign w_loop_acc = loop_valid && r_act;
    assign w_drop     = w_loop_acc && (host_hold || (r_loop_pend && !(w_launch && !w_sel_host)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_act       <= 1'b0;
            r_host_pend <= 1'b1;
            r_host_buf  <= DEFAULT_CODE;
            r_loop_pend <= 1'b0;
            r_loop_buf  <= '0;
            r_spi_data  <= '0;
            r_dac       <= DEFAULT_CODE;
            r_drop      <= 8'd0;
            r_err       <= 1'b0;
            r_gap       <= 16'd0;
            r_tmo       <= 4'd0;
        end else begin
            r_state <= w_nstate;
            r_act   <= 1'b1;
            if (w_launch)
                r_spi_data <= w_word;
            if (w_launch)
                r_tmo <= 4'd0;
            else if (r_state == S_START)
                r_tmo <= r_tmo + 4'd1;
            if (w_commit)
                r_dac <= r_spi_data;
            if (w_tmo)
                r_err <= 1'b1;
            if (w_commit || w_tmo)
                r_gap <= 16'(MIN_GAP - 1);
            else if (r_state == S_GAP)
                r_gap <= r_gap - 16'd1;

            if (host_valid && !r_host_pend) begin
                r_host_buf  <= host_code;
                r_host_pend <= 1'b1;
            end else if (w_launch && w_sel_host) begin
                r_host_pend <= 1'b0;
            end

            if (w_loop_acc && !host_hold) begin
                r_loop_buf  <= loop_code;
                r_loop_pend <= 1'b1;
            end else if (w_launch && !w_sel_host) begin
                r_loop_pend <= 1'b0;
            end

            if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    assign loop_ready = r_act;
    assign host_ready = !r_host_pend;
    assign spi_start  = w_launch;
    assign spi_data   = w_launch ? w_word : r_spi_data;
    assign dac_code   = r_dac;
    assign drop_cnt   = r_drop;
    assign spi_err    = r_err;
endmodule

// File: tb/tb_ref_dac_sched.sv
// Directed bench for ref_dac_sched: scoreboarded SPI words, launch timing, drops, timeout, hold.
module tb_ref_dac_sched;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        loop_valid = 1'b0;
    logic [15:0] loop_code = 16'h0;
    logic        loop_ready;
    logic        host_valid = 1'b0;
    logic [15:0] host_code = 16'h0;
    logic        host_ready;
    logic        host_hold = 1'b0;
    logic        spi_start;
    logic [15:0] spi_data;
    logic        spi_busy = 1'b0;
    logic [15:0] dac_code;
    logic [7:0]  drop_cnt;
    logic        spi_err;

    ref_dac_sched dut (
        .clk(clk), .reset_n(reset_n),
        .loop_valid(loop_valid), .loop_code(loop_code), .loop_ready(loop_ready),
        .host_valid(host_valid), .host_code(host_code), .host_ready(host_ready),
        .host_hold(host_hold), .spi_start(spi_start), .spi_data(spi_data),
        .spi_busy(spi_busy), .dac_code(dac_code), .drop_cnt(drop_cnt), .spi_err(spi_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          start_cyc[64];
    logic [15:0] exp_q[$];
    logic        prev_start = 1'b0;
    bit          ser_en = 1'b1;
    int          ser_len = 34;
    int          scnt = 0;
    logic [15:0] m_dac, w1, w2;
    int          n, sc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] slew(input logic [15:0] code, input logic [15:0] dac);
`ifdef REF_DAC_SLEW_EN
        int d;
        d = int'(code) - int'(dac);
        if (d > 256) return (int'(dac) + 256 > 65535) ? 16'hFFFF : 16'(int'(dac) + 256);
        if (d < -256) return (int'(dac) < 256) ? 16'h0000 : 16'(int'(dac) - 256);
`endif
        return code;
    endfunction

    always @(posedge clk) cyc++;

    // Serializer model: busy rises the cycle after the launch and stays high ser_len cycles.
    always @(negedge clk) begin
        spi_busy = (scnt != 0);
        if (spi_start && ser_en) scnt = ser_len;
        else if (scnt != 0) scnt--;
    end

    // Scoreboard: every launch pops one expected word.
    always @(negedge clk) begin
        if (spi_start) begin
            chk("start_not_back_to_back", 32'(prev_start), 32'h0);
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 32'(spi_data), 32'hFFFF_FFFF);
            end else begin
                chk("spi_data", 32'(spi_data), 32'(exp_q.pop_front()));
            end
            if (start_cnt < 64) start_cyc[start_cnt] = cyc;
            start_cnt++;
        end
        prev_start = spi_start;
    end

    task automatic wait_starts(input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (start_cnt >= target) break;
        end
        if (start_cnt < target) chk("start_timeout", 32'(start_cnt), 32'(target));
    endtask

    task automatic drive(input bit is_host, input logic [15:0] code);
        @(posedge clk); #1;
        if (is_host) begin host_valid = 1'b1; host_code = code; end
        else begin loop_valid = 1'b1; loop_code = code; end
        @(posedge clk); #1;
        host_valid = 1'b0;
        loop_valid = 1'b0;
    endtask

    task automatic xact(input string tag, input bit is_host, input logic [15:0] code,
                        input logic [15:0] word);
        exp_q.push_back(word);
        drive(is_host, code);
        wait_starts(start_cnt + 1, 20);
        repeat (15) @(negedge clk);
        chk(tag, 32'(dac_code), 32'(word));
        repeat (420) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_spi_start", 32'(spi_start), 32'h0);
        chk("rst_spi_data", 32'(spi_data), 32'h0);
        chk("rst_dac_code", 32'(dac_code), 32'h7FFF);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_spi_err", 32'(spi_err), 32'h0);
        chk("rst_loop_ready", 32'(loop_ready), 32'h0);
        chk("rst_host_ready", 32'(host_ready), 32'h0);

        // Default code is launched in the first cycle after release.
        exp_q.push_back(16'h7FFF);
        m_dac = 16'h7FFF;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_launch", 32'(spi_start), 32'h1);
        wait_starts(1, 10);
        ser_len = 10;
        repeat (40) @(negedge clk);
        chk("rel_dac_code", 32'(dac_code), 32'h7FFF);
        chk("rel_host_ready", 32'(host_ready), 32'h1);
        chk("rel_loop_ready", 32'(loop_ready), 32'h1);

        // Three loop writes during GAP: only the last survives, two drops.
        exp_q.push_back(slew(16'h8020, m_dac));
        @(posedge clk); #1 loop_valid = 1'b1; loop_code = 16'h8000;
        @(posedge clk); #1 loop_code = 16'h8010;
        @(posedge clk); #1 loop_code = 16'h8020;
        @(posedge clk); #1 loop_valid = 1'b0;
        @(negedge clk);
        chk("drop_two", 32'(drop_cnt), 32'h2);
        wait_starts(2, 600);
        chk("spacing_34", 32'(start_cyc[1] - start_cyc[0]), 32'd436);
        m_dac = slew(16'h8020, m_dac);

        // Host and loop pending together: host first, loop one gap later.
        repeat (20) @(posedge clk);
        #1 host_valid = 1'b1; host_code = 16'h1234; loop_valid = 1'b1; loop_code = 16'h5678;
        exp_q.push_back(16'h1234);
        exp_q.push_back(slew(16'h5678, 16'h1234));
        @(posedge clk); #1 host_valid = 1'b0; loop_valid = 1'b0;
        @(negedge clk);
        chk("host_ready_busy", 32'(host_ready), 32'h0);
        wait_starts(4, 1200);
        chk("host_after_gap", 32'(start_cyc[2] - start_cyc[1]), 32'd412);
        chk("loop_after_host", 32'(start_cyc[3] - start_cyc[2]), 32'd412);
        chk("drop_unchanged", 32'(drop_cnt), 32'h2);
        m_dac = slew(16'h5678, 16'h1234);
        repeat (15) @(negedge clk);
        chk("commit_loop", 32'(dac_code), 32'(m_dac));

        // Idle launch latency, plus a refill in the launch cycle that is not a drop.
        repeat (420) @(negedge clk);
        @(posedge clk); #1 loop_valid = 1'b1; loop_code = 16'h1300;
        n = cyc;
        w1 = slew(16'h1300, m_dac);
        w2 = slew(16'h1310, w1);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        @(posedge clk); #1 loop_code = 16'h1310;
        @(posedge clk); #1 loop_valid = 1'b0;
        wait_starts(5, 10);
        chk("launch_latency", 32'(start_cyc[4]), 32'(n + 1));
        chk("refill_no_drop", 32'(drop_cnt), 32'h2);
        wait_starts(6, 600);
        chk("refill_spacing", 32'(start_cyc[5] - start_cyc[4]), 32'd412);
        m_dac = w2;
        repeat (15) @(negedge clk);
        chk("commit_refill", 32'(dac_code), 32'(m_dac));
        repeat (420) @(negedge clk);

        // Serializer never goes busy: timeout sets spi_err, no commit.
        ser_en = 1'b0;
        exp_q.push_back(16'hABCD);
        drive(1'b1, 16'hABCD);
        wait_starts(7, 10);
        repeat (13) @(negedge clk);
        chk("err_not_early", 32'(spi_err), 32'h0);
        repeat (3) @(negedge clk);
        chk("err_set", 32'(spi_err), 32'h1);
        chk("err_no_commit", 32'(dac_code), 32'(m_dac));
        ser_en = 1'b1;
        w1 = slew(16'h4444, m_dac);
        exp_q.push_back(w1);
        drive(1'b0, 16'h4444);
        wait_starts(8, 600);
        chk("after_timeout_gap", 32'(start_cyc[7] - start_cyc[6]), 32'd416);
        m_dac = w1;
        repeat (15) @(negedge clk);
        chk("commit_after_err", 32'(dac_code), 32'(m_dac));
        chk("err_sticky", 32'(spi_err), 32'h1);
        repeat (420) @(negedge clk);

        // host_hold discards every loop write; counter saturates.
        sc = start_cnt;
        host_hold = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 loop_valid = 1'b1; loop_code = 16'(i);
        end
        @(posedge clk); #1 loop_valid = 1'b0; host_hold = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_no_spi", 32'(start_cnt), 32'(sc));
        chk("drop_saturate", 32'(drop_cnt), 32'hFF);

`ifdef REF_DAC_SLEW_EN
        xact("slew_base", 1'b1, 16'h7FFF, 16'h7FFF);
        xact("slew_up", 1'b0, 16'hFFFF, 16'h80FF);
        xact("slew_down", 1'b0, 16'h0000, 16'h7FFF);
        xact("slew_host_bypass", 1'b1, 16'hFFFF, 16'hFFFF);
`else
        xact("host_tail", 1'b1, 16'hFFFF, 16'hFFFF);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
